// File: rtl/reset_sequencer_pkg.sv
// Shared types and helpers for the reset sequencer.
package reset_sequencer_pkg;

  // Sequencer phases: all asserted, staggered release, all released.
  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } state_t;

  // Width of the domain index; never narrower than one bit.
  function automatic int idx_width(input int num_domains);
    if (num_domains <= 2) begin
      return 1;
    end
    return $clog2(num_domains);
  endfunction

endpackage

// File: rtl/reset_sequencer_timer.sv
// Up-counter shared by the HOLD and RELEASE phases. The caller supplies the
// terminal value for the current phase and clears the count when it hits it.
module reset_sequencer_timer
  import reset_sequencer_pkg::*;
#(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_sh,
  input  logic                 i_clr,
  input  logic                 i_en,
  input  logic [CNT_WIDTH-1:0] i_tc_val,
  output logic                 o_tc
);

  logic [CNT_WIDTH-1:0] cnt_q;

  // Count while enabled; a clear always wins so the count never wraps.
  always_ff @(posedge i_clk) begin
    if (i_rst_sh) begin
      cnt_q <= '0;
    end else if (i_clr) begin
      cnt_q <= '0;
    end else if (i_en) begin
      cnt_q <= cnt_q + CNT_WIDTH'(1);
    end
  end

  assign o_tc = (cnt_q == i_tc_val);

endmodule

// File: rtl/reset_sequencer.sv
// Per-clock-domain reset sequencer: holds every downstream domain in reset
// for HOLD_CYCLES, then releases them one at a time in index order every
// STAGGER_CYCLES. A rising edge on the software request while running
// replays the whole sequence and acknowledges its completion.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int NUM_DOMAINS    = 4,
  parameter int HOLD_CYCLES    = 16,
  parameter int STAGGER_CYCLES = 4,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst_sh,
  input  logic                   i_sw_req,
  output logic                   o_sw_ack,
  output logic [NUM_DOMAINS-1:0] o_rst_ah,
  output logic [NUM_DOMAINS-1:0] o_rst_al,
  output logic                   o_done
);

  localparam int IDX_W = idx_width(NUM_DOMAINS);

  // Reject parameter sets the timer or index cannot represent.
  if (NUM_DOMAINS < 1) begin : g_chk_domains
    $fatal(1, "reset_sequencer: NUM_DOMAINS must be >= 1");
  end
  if (HOLD_CYCLES < 1 || HOLD_CYCLES >= (1 << CNT_WIDTH)) begin : g_chk_hold
    $fatal(1, "reset_sequencer: HOLD_CYCLES out of range for CNT_WIDTH");
  end
  if (STAGGER_CYCLES < 1 || STAGGER_CYCLES >= (1 << CNT_WIDTH)) begin : g_chk_stagger
    $fatal(1, "reset_sequencer: STAGGER_CYCLES out of range for CNT_WIDTH");
  end

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NUM_DOMAINS-1:0] rst_ah_q, rst_ah_d;
  logic                   done_q, done_d;
  logic                   ack_q, ack_d;
  logic                   sw_pend_q, sw_pend_d;
  logic                   req_d_q;

  logic                   tmr_clr;
  logic                   tmr_en;
  logic                   tmr_tc;
  logic [CNT_WIDTH-1:0]   tmr_tc_val;
  logic                   sw_rise;

  assign sw_rise    = i_sw_req & ~req_d_q;
  assign tmr_tc_val = (state_q == HOLD) ? CNT_WIDTH'(HOLD_CYCLES - 1)
                                        : CNT_WIDTH'(STAGGER_CYCLES - 1);

  reset_sequencer_timer #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_timer (
    .i_clk    (i_clk),
    .i_rst_sh (i_rst_sh),
    .i_clr    (tmr_clr),
    .i_en     (tmr_en),
    .i_tc_val (tmr_tc_val),
    .o_tc     (tmr_tc)
  );

  // Next-state, next-output and timer control for the sequencer FSM.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    rst_ah_d  = rst_ah_q;
    done_d    = done_q;
    ack_d     = 1'b0;
    sw_pend_d = sw_pend_q;
    tmr_en    = 1'b0;
    tmr_clr   = 1'b0;

    unique case (state_q)
      HOLD: begin
        tmr_en = 1'b1;
        if (tmr_tc) begin
          tmr_clr = 1'b1;
          state_d = RELEASE;
        end
      end

      RELEASE: begin
        tmr_en = 1'b1;
        if (tmr_tc) begin
          tmr_clr = 1'b1;
          // Drop the reset of the domain currently being released.
          for (int k = 0; k < NUM_DOMAINS; k++) begin
            if (idx_q == IDX_W'(k)) begin
              rst_ah_d[k] = 1'b0;
            end
          end
          if (idx_q == IDX_W'(NUM_DOMAINS - 1)) begin
            state_d = RUN;
            done_d  = 1'b1;
            if (sw_pend_q) begin
              ack_d     = 1'b1;
              sw_pend_d = 1'b0;
            end
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end

      RUN: begin
        // Only a fresh rising edge restarts; a held request is ignored.
        if (sw_rise) begin
          state_d   = HOLD;
          idx_d     = '0;
          rst_ah_d  = '1;
          done_d    = 1'b0;
          sw_pend_d = 1'b1;
          tmr_clr   = 1'b1;
        end
      end

      default: begin
        state_d = HOLD;
      end
    endcase
  end

  // State and output registers; reset forces every domain into reset.
  always_ff @(posedge i_clk) begin
    if (i_rst_sh) begin
      state_q   <= HOLD;
      idx_q     <= '0;
      rst_ah_q  <= '1;
      done_q    <= 1'b0;
      ack_q     <= 1'b0;
      sw_pend_q <= 1'b0;
      req_d_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      rst_ah_q  <= rst_ah_d;
      done_q    <= done_d;
      ack_q     <= ack_d;
      sw_pend_q <= sw_pend_d;
      req_d_q   <= i_sw_req;
    end
  end

  assign o_rst_ah = rst_ah_q;
  assign o_rst_al = ~rst_ah_q;
  assign o_done   = done_q;
  assign o_sw_ack = ack_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: a default instance and a minimal
// (1 domain, 1-cycle hold/stagger) instance share the same stimulus.
module tb_reset_sequencer;

  localparam int H0 = 16, S0 = 4, N0 = 4;
  localparam int H1 = 1,  S1 = 1, N1 = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_sh = 1'b1;
  logic sw_req = 1'b0;

  logic       ack0, done0;
  logic [3:0] ah0, al0;
  logic       ack1, done1;
  logic [0:0] ah1, al1;

  reset_sequencer #(
    .NUM_DOMAINS(N0), .HOLD_CYCLES(H0), .STAGGER_CYCLES(S0), .CNT_WIDTH(8)
  ) dut0 (
    .i_clk(clk), .i_rst_sh(rst_sh), .i_sw_req(sw_req),
    .o_sw_ack(ack0), .o_rst_ah(ah0), .o_rst_al(al0), .o_done(done0)
  );

  reset_sequencer #(
    .NUM_DOMAINS(N1), .HOLD_CYCLES(H1), .STAGGER_CYCLES(S1), .CNT_WIDTH(8)
  ) dut1 (
    .i_clk(clk), .i_rst_sh(rst_sh), .i_sw_req(sw_req),
    .o_sw_ack(ack1), .o_rst_ah(ah1), .o_rst_al(al1), .o_done(done1)
  );

  int compared   = 0;
  int mismatched = 0;

  // Reference model state: edges since the sequence began, whether that
  // sequence was software-initiated, and the previous request level.
  int n_m    [2];
  bit sw_m   [2];
  bit reqd_m [2];

  // Expected word layout: {ack, done, rst_ah[3:0]}.
  logic [5:0] q0[$];
  logic [5:0] q1[$];

  task automatic check(input string name, input logic [5:0] got, input logic [5:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s @%0t: got %b want %b", name, $time, got, want);
    end
  endtask

  // Advance the model by one clock edge with the given inputs.
  task automatic model_step(input int d, input bit rst, input bit req, output logic [5:0] e);
    int h, s, nd, total;
    h     = (d == 0) ? H0 : H1;
    s     = (d == 0) ? S0 : S1;
    nd    = (d == 0) ? N0 : N1;
    total = h + nd * s;
    if (rst) begin
      n_m[d]    = 0;
      sw_m[d]   = 1'b0;
      reqd_m[d] = 1'b0;
    end else begin
      if (n_m[d] >= total && req && !reqd_m[d]) begin
        n_m[d]  = 0;
        sw_m[d] = 1'b1;
      end else if (n_m[d] <= total) begin
        n_m[d]++;
      end
      reqd_m[d] = req;
    end
    e = '0;
    for (int k = 0; k < nd; k++) begin
      e[k] = (n_m[d] < h + (k + 1) * s);
    end
    e[4] = (n_m[d] >= total);
    e[5] = sw_m[d] && (n_m[d] == total);
  endtask

  // Drive one cycle of stimulus and queue the response expected after it.
  task automatic cycle(input bit rst, input bit req);
    logic [5:0] e0, e1;
    @(negedge clk);
    rst_sh = rst;
    sw_req = req;
    model_step(0, rst, req, e0);
    model_step(1, rst, req, e1);
    q0.push_back(e0);
    q1.push_back(e1);
  endtask

  // Monitor: after every edge, pop expectations and compare both instances.
  always @(posedge clk) begin
    logic [5:0] exp0, exp1;
    #1;
    if (q0.size() > 0) begin
      exp0 = q0.pop_front();
      check("d0_outputs", {ack0, done0, ah0}, exp0);
      check("d0_rst_al", {2'b00, al0}, {2'b00, ~exp0[3:0]});
    end
    if (q1.size() > 0) begin
      exp1 = q1.pop_front();
      check("d1_outputs", {ack1, done1, 3'b000, ah1}, exp1);
      check("d1_rst_al", {5'b00000, al1}, {5'b00000, ~exp1[0]});
    end
  end

  initial begin
    bit req_r;
    bit rst_r;

    // Power-on reset then a full sequence into RUN.
    repeat (3) cycle(1'b1, 1'b0);
    repeat (40) cycle(1'b0, 1'b0);

    // One-cycle software request while running.
    cycle(1'b0, 1'b1);
    repeat (40) cycle(1'b0, 1'b0);

    // Request rising mid-sequence is dropped; request held into RUN is ignored.
    repeat (2) cycle(1'b1, 1'b0);
    repeat (9) cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b1);
    repeat (9) cycle(1'b0, 1'b0);
    repeat (50) cycle(1'b0, 1'b1);
    repeat (10) cycle(1'b0, 1'b0);

    // Reset reasserted after domain 0 has been released.
    cycle(1'b1, 1'b0);
    repeat (24) cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    repeat (40) cycle(1'b0, 1'b0);

    // Random request toggling with occasional resets.
    req_r = 1'b0;
    repeat (800) begin
      if ($urandom_range(0, 7) == 0) req_r = ~req_r;
      rst_r = ($urandom_range(0, 299) == 0);
      cycle(rst_r, req_r);
    end

    @(posedge clk);
    #2;
    check("q0_drained", 6'(q0.size()), 6'd0);
    check("q1_drained", 6'(q1.size()), 6'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
